hpdl_dump_tx: RTL and testbench

Read-back streamer for the 16-place HPDL-1414 character buffer. On a dump request it reads the character memory in place order, sanitises each byte to the display's 64-character set, and hands the bytes one at a time to the UART transmitter, optionally followed by CR/LF. It sits between the character memory's read port and the UART transmitter's start/busy handshake. It is the host-facing reader for the buffer that the UART receive path writes.

---
 rtl/hpdl_dump_tx.sv | 176 +++++++++++++++++
 tb/tb_hpdl_dump_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdl_dump_tx.sv
// hpdl_dump_tx
// Read-back streamer for the HPDL-1414 character buffer. A dump request walks
// the character memory in place order, maps each byte onto the display's
// 64-character set and hands bytes one at a time to the UART transmitter,
// optionally followed by CR/LF.
//
// Ports:
//   clk                 system clock (12 MHz)
//   rst                 synchronous active-high reset
//   i_dump_req          start-dump pulse, honoured only while idle
//   i_length            places to send (0..31, clamped to DEPTH)
//   o_busy              dump in progress
//   o_done              one-cycle completion pulse
//   o_mem_read_enable   character memory read strobe
//   o_mem_read_address  place index being read
//   i_mem_read_data     memory data, valid the cycle after the strobe
//   o_tx_start          one-cycle transmitter start
//   o_tx_data           byte presented to the transmitter
//   i_tx_busy           transmitter busy
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_dump_req
// READ  | memory strobe issued for place idx
// LATCH | memory byte sanitised into o_tx_data, start if tx is free
// SEND  | byte loaded, waiting for tx to go idle before starting
// ACK   | start issued, waiting for tx to raise busy
// DRAIN | waiting for tx to finish the frame
// CR    | load 8'h0D, start if tx is free
// LF    | load 8'h0A, start if tx is free
// DONE  | pulse o_done, drop o_busy
module hpdl_dump_tx #(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int APPEND_CRLF = 1,
   parameter int SANITIZE    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_dump_req,
   input  logic [4:0]        i_length,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_mem_read_enable,
   output logic [ADDR_W-1:0] o_mem_read_address,
   input  logic [7:0]        i_mem_read_data,
   output logic              o_tx_start,
   output logic [7:0]        o_tx_data,
   input  logic              i_tx_busy
);

   // One extra bit so a full-depth length (16) does not alias to 0.
   localparam int LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   typedef enum logic [3:0] {
      S_IDLE, S_READ, S_LATCH, S_SEND, S_ACK, S_DRAIN, S_CR, S_LF, S_DONE
   } state_t;

   typedef enum logic [1:0] {K_DATA, K_CR, K_LF} kind_t;

   state_t            state;
   kind_t             kind;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  idx;
   logic [LEN_W-1:0]  idx_next;
   logic [LEN_W-1:0]  len_clamped;
   state_t            tail_state;

   function automatic logic [7:0] sanitize(input logic [7:0] b);
      if (SANITIZE != 0 && (b[7] || b < 8'h20 || b > 8'h5F))
         return 8'h3F;
      return b;
   endfunction

   assign idx_next   = idx + LEN_W'(1);
   assign tail_state = (APPEND_CRLF != 0) ? S_CR : S_DONE;

   always_comb begin
      len_clamped = LEN_W'(i_length);
      if ({1'b0, i_length} > 6'(DEPTH))
         len_clamped = DEPTH_L;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= S_IDLE;
         kind               <= K_DATA;
         len                <= '0;
         idx                <= '0;
         o_busy             <= 1'b0;
         o_done             <= 1'b0;
         o_tx_start         <= 1'b0;
         o_tx_data          <= 8'h00;
         o_mem_read_enable  <= 1'b0;
         o_mem_read_address <= '0;
      end else begin
         // Strobes are single-cycle unless a state re-asserts them.
         o_tx_start        <= 1'b0;
         o_mem_read_enable <= 1'b0;
         o_done            <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_dump_req) begin
                  o_busy <= 1'b1;
                  len    <= len_clamped;
                  idx    <= '0;
                  if (len_clamped == '0) begin
                     state <= tail_state;
                  end else begin
                     o_mem_read_enable  <= 1'b1;
                     o_mem_read_address <= '0;
                     state              <= S_READ;
                  end
               end
            end
            S_READ: state <= S_LATCH;
            S_LATCH: begin
               o_tx_data <= sanitize(i_mem_read_data);
               kind      <= K_DATA;
               if (!i_tx_busy) begin
                  o_tx_start <= 1'b1;
                  state      <= S_ACK;
               end else begin
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               if (!i_tx_busy) begin
                  o_tx_start <= 1'b1;
                  state      <= S_ACK;
               end
            end
            S_ACK: begin
               if (i_tx_busy)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!i_tx_busy) begin
                  case (kind)
                     K_DATA: begin
                        idx <= idx_next;
                        if (idx_next < len) begin
                           o_mem_read_enable  <= 1'b1;
                           o_mem_read_address <= idx_next[ADDR_W-1:0];
                           state              <= S_READ;
                        end else begin
                           state <= tail_state;
                        end
                     end
                     K_CR:    state <= S_LF;
                     default: state <= S_DONE;
                  endcase
               end
            end
            S_CR, S_LF: begin
               o_tx_data <= (state == S_CR) ? 8'h0D : 8'h0A;
               kind      <= (state == S_CR) ? K_CR : K_LF;
               if (!i_tx_busy) begin
                  o_tx_start <= 1'b1;
                  state      <= S_ACK;
               end else begin
                  state <= S_SEND;
               end
            end
            S_DONE: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hpdl_dump_tx.sv
module tb_hpdl_dump_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic [4:0] len_in = '0;
   logic       o_busy, o_done, o_mem_read_enable, o_tx_start;
   logic [3:0] o_mem_read_address;
   logic [7:0] o_tx_data;
   logic [7:0] mem_rdata = 8'h00;
   logic       tx_busy = 1'b0;
   logic       force_busy = 1'b0;
   wire        dut_tx_busy = tx_busy | force_busy;

   // Second instance without CR/LF, only exercised with zero-length dumps.
   logic       req2 = 1'b0;
   logic [4:0] len2 = '0;
   logic       busy2, done2, re2, start2;
   logic [3:0] addr2;
   logic [7:0] data2;

   logic [7:0] mem [16];
   logic [7:0] tx_q [$];
   logic [3:0] rd_q [$];
   logic [7:0] exp_q [$];
   int         frame = 10;
   int         busy_cnt = 0;
   int         n_start = 0, n_done = 0, n_start2 = 0, n_bad_start = 0;
   int         n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   hpdl_dump_tx dut (
      .clk(clk), .rst(rst), .i_dump_req(req), .i_length(len_in),
      .o_busy(o_busy), .o_done(o_done),
      .o_mem_read_enable(o_mem_read_enable), .o_mem_read_address(o_mem_read_address),
      .i_mem_read_data(mem_rdata), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
      .i_tx_busy(dut_tx_busy)
   );

   hpdl_dump_tx #(.APPEND_CRLF(0)) dut_nocrlf (
      .clk(clk), .rst(rst), .i_dump_req(req2), .i_length(len2),
      .o_busy(busy2), .o_done(done2),
      .o_mem_read_enable(re2), .o_mem_read_address(addr2),
      .i_mem_read_data(8'h41), .o_tx_start(start2), .o_tx_data(data2),
      .i_tx_busy(1'b0)
   );

   // Memory with one-cycle read latency, UART transmitter that raises busy
   // the cycle after start and keeps it for 'frame' cycles, plus monitors.
   always @(posedge clk) begin
      if (o_mem_read_enable) begin
         mem_rdata <= mem[o_mem_read_address];
         rd_q.push_back(o_mem_read_address);
      end
      if (o_tx_start) begin
         tx_q.push_back(o_tx_data);
         n_start++;
         if (dut_tx_busy) n_bad_start++;
      end
      if (o_done) n_done++;
      if (start2) n_start2++;
      if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) tx_busy <= 1'b0;
      end else if (o_tx_start) begin
         busy_cnt <= frame;
         tx_busy  <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] ref_char(input logic [7:0] b);
      return (b >= 8'h20 && b <= 8'h5F) ? b : 8'h3F;
   endfunction

   task automatic build_exp(input int len);
      int n;
      n = (len > 16) ? 16 : len;
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(ref_char(mem[i]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic clear_mon();
      tx_q.delete();
      rd_q.delete();
      n_start = 0;
      n_done  = 0;
   endtask

   // Returns at the falling edge of the cycle after acceptance.
   task automatic start_req(input int len);
      @(negedge clk);
      req    = 1'b1;
      len_in = len[4:0];
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (n_done == 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_dump(input string tag, input int len);
      int m, n;
      n = (len > 16) ? 16 : len;
      build_exp(len);
      chk({tag, "_nbytes"}, tx_q.size(), exp_q.size());
      m = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) chk({tag, "_byte"}, tx_q[i], exp_q[i]);
      chk({tag, "_starts"}, n_start, exp_q.size());
      chk({tag, "_done_cnt"}, n_done, 1);
      chk({tag, "_busy_after"}, o_busy, 1'b0);
      chk({tag, "_reads"}, rd_q.size(), n);
      for (int i = 0; i < rd_q.size(); i++) chk({tag, "_raddr"}, rd_q[i], i[3:0]);
   endtask

   initial begin
      int k, snap, l;
      repeat (3) @(negedge clk);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_start", o_tx_start, 0);
      chk("rst_data", o_tx_data, 8'h00);
      chk("rst_re", o_mem_read_enable, 0);
      chk("rst_addr", o_mem_read_address, 0);
      chk("rst_busy2", busy2, 0);
      rst = 1'b0;

      // "ABCD..." with a 10-cycle transmitter, plus first-byte latency.
      for (int i = 0; i < 16; i++) mem[i] = 8'(8'h41 + i);
      clear_mon();
      start_req(4);
      chk("t1_busy", o_busy, 1);
      chk("t1_re", o_mem_read_enable, 1);
      chk("t1_addr", o_mem_read_address, 0);
      @(negedge clk);
      chk("t1_re_low", o_mem_read_enable, 0);
      chk("t1_no_start", o_tx_start, 0);
      @(negedge clk);
      chk("t1_start", o_tx_start, 1);
      chk("t1_data", o_tx_data, 8'h41);
      wait_done("t1", 3000);
      check_dump("t1", 4);

      // Zero length: CR/LF only, no reads.
      clear_mon();
      start_req(0);
      wait_done("t2", 3000);
      check_dump("t2", 0);

      // Zero length without CR/LF: done two cycles after acceptance.
      @(negedge clk);
      req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      chk("t2b_busy", busy2, 1);
      chk("t2b_done_early", done2, 0);
      @(negedge clk);
      chk("t2b_done", done2, 1);
      chk("t2b_busy_low", busy2, 0);
      @(negedge clk);
      chk("t2b_done_pulse", done2, 0);
      chk("t2b_re", re2, 0);
      chk("t2b_data", data2, 8'h00);
      chk("t2b_addr", addr2, 0);

      // Over-long request clamps to 16 places, no address wrap.
      for (int i = 0; i < 16; i++) mem[i] = 8'h5A;
      clear_mon();
      start_req(20);
      wait_done("t3", 3000);
      check_dump("t3", 20);

      // Out-of-set bytes.
      mem[0] = 8'h7B; mem[1] = 8'h1F; mem[2] = 8'hC1; mem[3] = 8'h20;
      clear_mon();
      start_req(4);
      wait_done("t4", 3000);
      check_dump("t4", 4);
      chk("t4_last_char", tx_q.size() > 3 ? 32'(tx_q[3]) : 32'hFFFF, 32'h20);

      // Second request during the third byte is ignored.
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      clear_mon();
      start_req(6);
      k = 0;
      while (n_start < 3 && k < 2000) begin @(negedge clk); k++; end
      chk("t5_third_seen", 32'(n_start >= 3), 32'd1);
      req = 1'b1; len_in = 5'd16;
      @(negedge clk);
      req = 1'b0;
      wait_done("t5", 3000);
      repeat (60) @(negedge clk);
      check_dump("t5", 6);

      // Reset while waiting for the second byte's handshake.
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      clear_mon();
      start_req(4);
      k = 0;
      while (n_start < 2 && k < 2000) begin @(negedge clk); k++; end
      chk("t6_second_seen", n_start, 2);
      chk("t6_in_flight", o_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_busy", o_busy, 0);
      chk("t6_done", o_done, 0);
      chk("t6_start", o_tx_start, 0);
      chk("t6_data", o_tx_data, 8'h00);
      chk("t6_re", o_mem_read_enable, 0);
      chk("t6_addr", o_mem_read_address, 0);
      rst = 1'b0;
      snap = n_start;
      repeat (2000) @(negedge clk);
      chk("t6_quiet", n_start, snap);
      clear_mon();
      start_req(3);
      wait_done("t6b", 3000);
      check_dump("t6b", 3);

      // Transmitter busy at request time.
      clear_mon();
      force_busy = 1'b1;
      start_req(2);
      repeat (20) @(negedge clk);
      chk("t7_held", n_start, 0);
      chk("t7_busy", o_busy, 1);
      force_busy = 1'b0;
      chk("t7_start_low", o_tx_start, 0);
      @(negedge clk);
      chk("t7_start", o_tx_start, 1);
      wait_done("t7", 3000);
      check_dump("t7", 2);

      // Random contents, lengths and frame times.
      for (int r = 0; r < 8; r++) begin
         frame = $urandom_range(2, 30);
         for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
         l = $urandom_range(0, 20);
         clear_mon();
         start_req(l);
         wait_done("rnd", 3000);
         check_dump("rnd", l);
      end

      chk("no_start_while_busy", n_bad_start, 0);
      chk("nocrlf_no_start", n_start2, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
